data_mem_ctrl: RTL and testbench

Parametrised, byte-addressable RISC-V data memory with a request/response handshake, configurable response latency and RV32I load/store sizing (LB/LH/LW/LBU/LHU/SB/SH/SW). On reset it clears itself by sweeping every word to INIT_VALUE, one word per clock. It flags misaligned, out-of-range and illegal-size accesses. It sits between the MEM-stage control and the writeback mux, replacing the word-only combinational-read data memory.

---
 rtl/data_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// RV32I data memory with a request/response handshake, configurable response latency
// and a self-clearing init sweep after reset.
module data_mem_ctrl #(
  parameter int          DEPTH        = 64,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] INIT_VALUE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are
  // both high; rsp_valid is a one-cycle strobe and rsp_rdata/rsp_fault are only
  // meaningful (and otherwise zero) while it is high.
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [AW-1:0] init_ptr;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   pend_data;
  logic          pend_fault;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ext_data;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic [31:0]   result;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  always_comb begin
    accept       = (state == IDLE) && req_valid;
    idx          = req_addr[AW+1:2];
    lane         = req_addr[1:0];
    word         = mem[idx];
    byte_v       = word[{lane, 3'b000} +: 8];
    half_v       = req_addr[1] ? word[31:16] : word[15:0];
    ext_data     = 32'd0;
    case (req_funct3)
      3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext_data = {24'd0, byte_v};
      3'b001:  ext_data = {{16{half_v[15]}}, half_v};
      3'b101:  ext_data = {16'd0, half_v};
      3'b010:  ext_data = word;
      default: ext_data = 32'd0;
    endcase
    illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                   (req_we && req_funct3[2]);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >> (AW + 2)) != 32'd0;
    fault        = illegal || misaligned || out_of_range;
    result       = (fault || req_we) ? 32'd0 : ext_data;
    // Replicate store data across lanes so the byte enables alone select placement.
    be           = 4'b0000;
    wdata_rep    = req_wdata;
    if (accept && req_we && !fault) begin
      case (req_funct3[1:0])
        2'b00: begin
          be        = 4'b0001 << lane;
          wdata_rep = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be        = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{req_wdata[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end
  end

  // The array has no reset; the sweep in INIT is what clears it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_ptr] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      init_ptr   <= '0;
      wait_cnt   <= '0;
      pend_data  <= 32'd0;
      pend_fault <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_fault  <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (READ_LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= result;
              rsp_fault <= fault;
            end else begin
              state      <= WAIT;
              wait_cnt   <= WAIT_LOAD;
              pend_data  <= result;
              pend_fault <= fault;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_data;
            rsp_fault <= pend_fault;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance at latency 1 and one at latency 3 share the
// request fields; a reference memory model fills per-instance expected queues.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        rdy1, rdy3, rv1, rv3, rf1, rf3, id1, id3;
  logic [31:0] rd1, rd3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q3[$];
  logic [31:0] model_mem [64];
  logic [32:0] e1, e3;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(64), .READ_LATENCY(1), .INIT_VALUE(32'h0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_fault(rf1), .init_done(id1));

  data_mem_ctrl #(.DEPTH(64), .READ_LATENCY(3), .INIT_VALUE(32'h0)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(we),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv3),
    .rsp_rdata(rd3), .rsp_fault(rf3), .init_done(id3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: returns {fault, rdata} and applies legal stores.
  task automatic model_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output logic [32:0] res);
    logic flt;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;
    flt = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && (f == 3'd4 || f == 3'd5)) ||
          ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'b00) ||
          (a >= 32'd256);
    res = 33'd0;
    if (flt) begin
      res = {1'b1, 32'd0};
    end else begin
      wd = model_mem[a[7:2]];
      if (w) begin
        case (f)
          3'd0:    wd[8*a[1:0] +: 8] = d[7:0];
          3'd1:    wd[16*a[1] +: 16] = d[15:0];
          default: wd = d;
        endcase
        model_mem[a[7:2]] = wd;
      end else begin
        b = wd[8*a[1:0] +: 8];
        h = wd[16*a[1] +: 16];
        case (f)
          3'd0:    res[31:0] = {{24{b[7]}}, b};
          3'd4:    res[31:0] = {24'd0, b};
          3'd1:    res[31:0] = {{16{h[15]}}, h};
          3'd5:    res[31:0] = {16'd0, h};
          default: res[31:0] = wd;
        endcase
      end
    end
  endtask

  // Called at a falling edge; returns at a falling edge once every targeted DUT accepted.
  task automatic do_req(input bit t1, input bit t3, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
    logic [32:0] e;
    bit a1, a3;
    int n;
    model_req(w, f, a, d, e);
    if (t1) exp_q1.push_back(e);
    if (t3) exp_q3.push_back(e);
    we = w; f3 = f; addr = a; wdata = d;
    v1 = t1; v3 = t3;
    n = 0;
    while ((v1 || v3) && n < 100) begin
      a1 = v1 && rdy1;
      a3 = v3 && rdy3;
      @(posedge clk); #1;
      if (a1) v1 = 1'b0;
      if (a3) v3 = 1'b0;
      @(negedge clk);
      n++;
    end
    if (v1 || v3) begin
      check("drv_timeout", 1, 0);
      v1 = 1'b0;
      v3 = 1'b0;
    end
  endtask

  task automatic reset_and_init();
    int d1, d3;
    reset = 1'b0;
    v1 = 1'b0;
    v3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state1", {rdy1, rv1, rf1, id1, rd1}, 0);
    check("rst_state3", {rdy3, rv3, rf3, id3, rd3}, 0);
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    reset = 1'b1;
    d1 = 0;
    d3 = 0;
    for (int n = 1; n <= 200 && (d1 == 0 || d3 == 0); n++) begin
      @(posedge clk); #1;
      if (id1 && d1 == 0) d1 = n;
      if (id3 && d3 == 0) d3 = n;
    end
    check("init_cycles1", d1, 64);
    check("init_cycles3", d3, 64);
    @(negedge clk);
    check("ready_after_init1", rdy1, 1);
    check("ready_after_init3", rdy3, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy1 && rdy3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(rdy1 && rdy3)) check("idle_timeout", 0, 1);
  endtask

  // Cycle-exact response timing, plus an ignored req_valid pulse during WAIT.
  task automatic timing_probe(input bit sel);
    logic [32:0] e;
    int lat;
    lat = sel ? 3 : 1;
    wait_idle();
    model_req(1'b0, 3'd2, 32'h10, 32'd0, e);
    if (sel) exp_q3.push_back(e);
    else exp_q1.push_back(e);
    we = 1'b0; f3 = 3'd2; addr = 32'h10;
    if (sel) v3 = 1'b1;
    else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    v3 = 1'b0;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      check($sformatf("t%0d_valid_k%0d", lat, k), sel ? rv3 : rv1, (k == lat - 1));
      check($sformatf("t%0d_ready_k%0d", lat, k), sel ? rdy3 : rdy1, (k >= lat));
      if (sel && k == 0) v3 = 1'b1;
      if (k == 1) v3 = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rv1) begin
        if (exp_q1.size() == 0) check("rsp1_extra", 1, 0);
        else begin
          e1 = exp_q1.pop_front();
          check("rsp1", {rf1, rd1}, e1);
        end
      end else check("quiet1", {rf1, rd1}, 0);
      if (rv3) begin
        if (exp_q3.size() == 0) check("rsp3_extra", 1, 0);
        else begin
          e3 = exp_q3.pop_front();
          check("rsp3", {rf3, rd3}, e3);
        end
      end else check("quiet3", {rf3, rd3}, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_and_init();
    for (int i = 0; i < 64; i++) do_req(1, 1, 1'b0, 3'd2, 32'(i * 4), 32'd0);
    // Word store then sized loads.
    do_req(1, 1, 1'b1, 3'd2, 32'h10, 32'h12345678);
    do_req(1, 1, 1'b0, 3'd2, 32'h10, 32'd0);
    do_req(1, 1, 1'b0, 3'd4, 32'h13, 32'd0);
    do_req(1, 1, 1'b0, 3'd1, 32'h10, 32'd0);
    do_req(1, 1, 1'b0, 3'd5, 32'h12, 32'd0);
    // Byte store into a zero word, then sign/zero-extending loads.
    do_req(1, 1, 1'b1, 3'd0, 32'h21, 32'hFFFFFFAB);
    do_req(1, 1, 1'b0, 3'd2, 32'h20, 32'd0);
    do_req(1, 1, 1'b0, 3'd0, 32'h21, 32'd0);
    do_req(1, 1, 1'b0, 3'd4, 32'h21, 32'd0);
    do_req(1, 1, 1'b1, 3'd1, 32'h22, 32'h00008001);
    do_req(1, 1, 1'b0, 3'd1, 32'h22, 32'd0);
    do_req(1, 1, 1'b0, 3'd2, 32'h20, 32'd0);
    // Faulting requests must leave memory untouched.
    do_req(1, 1, 1'b0, 3'd2, 32'h02, 32'd0);
    do_req(1, 1, 1'b1, 3'd1, 32'h03, 32'h0000BEEF);
    do_req(1, 1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    do_req(1, 1, 1'b0, 3'd3, 32'h10, 32'd0);
    do_req(1, 1, 1'b1, 3'd4, 32'h10, 32'hCAFEF00D);
    do_req(1, 1, 1'b0, 3'd2, 32'h00, 32'd0);
    do_req(1, 1, 1'b0, 3'd2, 32'h10, 32'd0);
    timing_probe(1'b0);
    timing_probe(1'b1);
    for (int i = 0; i < 80; i++) begin
      do_req(1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 63)),
             $urandom);
    end
    do_req(1, 1, 1'b1, 3'd2, 32'h30, 32'hA5A5A5A5);
    wait_idle();
    repeat (4) @(negedge clk);
    // Abort a latency-3 load two cycles in; no response may follow.
    we = 1'b0; f3 = 3'd2; addr = 32'h30; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    check("abort_no_rsp_a", rv3, 0);
    @(negedge clk);
    check("abort_no_rsp_b", rv3, 0);
    reset_and_init();
    do_req(1, 1, 1'b0, 3'd2, 32'h30, 32'd0);
    do_req(1, 1, 1'b0, 3'd2, 32'h10, 32'd0);
    wait_idle();
    repeat (6) @(negedge clk);
    check("q1_drained", exp_q1.size(), 0);
    check("q3_drained", exp_q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
